// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [31:0] DEF_VEC_BASE = 32'h0000_0100;

endpackage

// File: rtl/irq_ctrl_sync.sv
// Per-source synchroniser chain with a one-cycle history for edge detection.
module irq_sync #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] s_s,
    output logic [N-1:0] s_d_s,
    output logic [N-1:0] rise_s
);

    logic [N-1:0] stage_r [STAGES];
    logic [N-1:0] s_d_r;

    // Shift raw lines through the synchroniser and keep the previous output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {N{1'b0}};
            end
            s_d_r <= {N{1'b0}};
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            s_d_r <= stage_r[STAGES-1];
        end
    end

    assign s_s    = stage_r[STAGES-1];
    assign s_d_s  = s_d_r;
    assign rise_s = s_s & ~s_d_r;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: enable/mode/pending registers, fixed
// lowest-index priority and a REQ/SERVICE/EOI handshake towards the core.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = DEF_VEC_BASE,
    parameter int          ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             irq_req,
    input  logic             irq_ack,
    input  logic             eoi,
    output logic [ID_W-1:0]  irq_id,
    output logic [31:0]      irq_vector
);

    logic [N_SRC-1:0] s_s, s_d_s, rise_s;
    logic [N_SRC-1:0] en_r, mode_r, pend_r, pend_nxt_s;
    logic [N_SRC-1:0] wmask_s, clr_s, claimable_s, win_mask_s, pend_view_s;
    logic [ID_W-1:0]  id_r, id_nxt_s, win_id_s;
    logic [31:0]      vec_r;
    logic             irq_req_r, any_s, claim_s, unused_s;
    state_e           state_r, state_nxt_s;

    irq_sync #(.N(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (irq_src),
        .s_s    (s_s),
        .s_d_s  (s_d_s),
        .rise_s (rise_s)
    );

    assign wmask_s  = cfg_wdata[N_SRC-1:0];
    assign unused_s = ^cfg_wdata;

    // Enable and mode registers; writes to PENDING/STATUS do not touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r   <= {N_SRC{1'b0}};
            mode_r <= {N_SRC{1'b0}};
        end else if (cfg_we) begin
            case (cfg_addr)
                REG_ENABLE: en_r   <= wmask_s;
                REG_MODE:   mode_r <= wmask_s;
                default:    ;
            endcase
        end
    end

    // A level source must be seen high for two synchronised samples before it
    // can be claimed, which aligns its latency with an edge source.
    assign claimable_s = en_r & ((mode_r & pend_r) | (~mode_r & s_s & s_d_s));
    assign win_mask_s  = claimable_s & (~claimable_s + N_SRC'(1'b1));
    assign any_s       = |claimable_s;
    assign claim_s     = (state_r == ST_IDLE) && any_s;

    // Encode the one-hot winner into a source id.
    always_comb begin
        win_id_s = {ID_W{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            win_id_s = win_id_s | (win_mask_s[i] ? ID_W'(i) : {ID_W{1'b0}});
        end
    end

    // Edge pending: W1C or claim clears, a new enabled edge sets and wins.
    always_comb begin
        clr_s      = ({N_SRC{cfg_we && (cfg_addr == REG_PENDING)}} & wmask_s)
                   | ({N_SRC{claim_s}} & win_mask_s);
        pend_nxt_s = mode_r & ((pend_r & ~clr_s) | (rise_s & en_r));
    end

    // Edge pending register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= {N_SRC{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Next-state logic; the id is latched only on a claim.
    always_comb begin
        state_nxt_s = state_r;
        id_nxt_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nxt_s = ST_REQ;
                    id_nxt_s    = win_id_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt_s = ST_SERVICE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, id and the registered request/vector outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            id_r      <= {ID_W{1'b0}};
            irq_req_r <= 1'b0;
            vec_r     <= VEC_BASE;
        end else begin
            state_r   <= state_nxt_s;
            id_r      <= id_nxt_s;
            irq_req_r <= (state_nxt_s == ST_REQ);
            vec_r     <= VEC_BASE + {{(30-ID_W){1'b0}}, id_nxt_s, 2'b00};
        end
    end

    assign irq_req    = irq_req_r;
    assign irq_id     = id_r;
    assign irq_vector = vec_r;
    assign pend_view_s = (mode_r & pend_r) | (~mode_r & s_s & en_r);

    // Combinational register read port.
    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            REG_ENABLE:  cfg_rdata[N_SRC-1:0] = en_r;
            REG_MODE:    cfg_rdata[N_SRC-1:0] = mode_r;
            REG_PENDING: cfg_rdata[N_SRC-1:0] = pend_view_s;
            REG_STATUS: begin
                cfg_rdata[ID_W+1:2] = id_r;
                cfg_rdata[1:0]      = state_r;
            end
            default:     cfg_rdata = 32'd0;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised multi-source interrupt controller that generalises the core's single I_Req/IACK pair to N_SRC sources.
- Provides per-source enable, per-source edge/level mode, fixed priority, a vector address output, and an in-service/end-of-interrupt (EOI) handshake.
- Sits between peripheral interrupt lines and the pipeline core: drives the core's interrupt request and consumes its acknowledge.
- Configured through a small word-register port on the data-memory side.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32).
- SYNC_STAGES, 2, synchroniser flops per source input (>=1).
- VEC_BASE, 32'h0000_0100, vector of source 0; vector(id) = VEC_BASE + id*4.
- ID_W, $clog2(N_SRC) (min 1), width of the source id.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- irq_src  in  N_SRC  raw asynchronous peripheral interrupt lines.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  register select: 0 ENABLE, 1 MODE (1=edge), 2 PENDING, 3 STATUS.
- cfg_wdata  in  32  config write data; bits >= N_SRC ignored.
- cfg_rdata  out  32  combinational read of the register at cfg_addr.
- irq_req  out  1  interrupt request to the core.
- irq_ack  in  1  core acknowledge; level, registered copy of irq_req.
- eoi  in  1  single-cycle end-of-interrupt pulse.
- irq_id  out  ID_W  id of the requested or in-service source.
- irq_vector  out  32  VEC_BASE + irq_id*4.

Behaviour:
- Reset (async): ENABLE=0, MODE=0, pending=0, synchronisers=0, state=IDLE, irq_req=0, irq_id=0, irq_vector=VEC_BASE, cfg_rdata reflects the zeroed registers.
- Synchroniser: each irq_src bit passes through SYNC_STAGES flops, giving s[i]; s_d[i] holds the previous value for edge detection.
- Pending, level source (MODE[i]=0): pend[i] = s[i] & ENABLE[i]. Combinational from the synchroniser; not writable.
- Pending, edge source (MODE[i]=1): pend[i] is a register.
  - Set on s[i] & ~s_d[i] & ENABLE[i].
  - Cleared on claim (IDLE->REQ with that id) or on a W1C write to PENDING.
  - Set and clear in the same cycle: set wins.
- Priority: the lowest-index pending bit wins.
- State machine (registered):
  - IDLE: if any pend, latch id = winner, state <= REQ. irq_req=0.
  - REQ: irq_req=1; id frozen; cannot be withdrawn even if the source drops or is disabled. On irq_ack=1, state <= SERVICE.
  - SERVICE: irq_req=0; id held; other pending sources wait (no nesting). On eoi=1, state <= IDLE. The next claim occurs no earlier than the following cycle.
- Ignored events:
  - eoi in IDLE or REQ.
  - irq_ack in IDLE or SERVICE.
  - Config writes never change the state or the latched id.
- Latency: a source rising in cycle 0, enabled, with state=IDLE → irq_req=1 after SYNC_STAGES+2 rising clk edges.
- Register writes take effect on the next clock edge; cfg_rdata is combinational.
  - PENDING read returns pend, zero-extended.
  - STATUS = {27'b0 | irq_id (ID_W bits at [ID_W+1:2]), state[1:0]}, with IDLE=0, REQ=1, SERVICE=2.
  - Write to STATUS: ignored.
- Level source deasserting during SERVICE: no effect; it re-requests only if still high after EOI.
- Disabling a source clears its level pending immediately. Edge pending bits stay set but cannot be claimed while disabled.

Decomposition:
- Package irq_ctrl_pkg: state enum (IDLE, REQ, SERVICE), register address localparams, default VEC_BASE.
- Sub-module irq_sync: a SYNC_STAGES-deep synchroniser plus edge detector per source, instantiated as a vector.
- Priority encoder, pending logic and FSM stay in irq_ctrl.

Test Plan:
- Reset mid-REQ: source 2 in REQ, assert reset → irq_req=0, STATUS=0, ENABLE=0, irq_vector=32'h100 immediately.
- Level source 3 enabled, irq_src=8'h08 → irq_req=1 after 4 cycles, irq_id=3, irq_vector=32'h10C. Then ack → SERVICE (STATUS=0x0E); eoi with source still high → REQ again.
- Edge sources 1 and 5 enabled, both pulsed in the same cycle → id 1 served first. After its eoi, id 5 is requested with irq_vector=32'h114; PENDING reads 0 after both claims.
- Edge source 0 pulses again during its own SERVICE → pend[0] re-sets; a second request follows the eoi. A W1C PENDING write coincident with a new edge leaves pend[0]=1.
- ENABLE cleared for source 4 while in REQ with id 4 → irq_req stays 1 until ack, id stays 4. eoi and ack pulses in IDLE → no state change.
- N_SRC=1, SYNC_STAGES=1 build: edge on irq_src → irq_req after 3 cycles, irq_id=0, irq_vector=VEC_BASE.
